periph_async_rx: RTL
====================

// Module: periph_async_rx
// PURPOSE
// - Receive side of the CPU_async send/ack link: consumes words the CPU pushes with a
//   4-phase handshake (send, data) and returns ack.
// - Synchronises send into clk and buffers words in a small FIFO.
// - Presents words downstream on a valid/ready interface.
// - Sits directly downstream of CPU_async: CPU.send -> send, CPU.ack <- ack.
// PARAMETERS
// - DATA_W  8  width of data_in / out_data
// - DEPTH   4  FIFO entries, power of 2, >=2
// - CNT_W   3  width of count; equals log2(DEPTH)+1
// PORTS
// - clk       in   1        rising-edge clock
// - rst       in   1        synchronous, active-high reset
// - send      in   1        request from CPU; asynchronous to clk
// - data_in   in   DATA_W   CPU data; stable while send=1
// - ack       out  1        acknowledge to CPU; registered
// - out_data  out  DATA_W   FIFO head word
// - out_valid out  1        FIFO non-empty
// - out_ready in   1        downstream pops the head when out_valid & out_ready
// - count     out  CNT_W    FIFO occupancy, 0..DEPTH
// BEHAVIOUR
// - Reset: ack=0, out_valid=0, out_data=0, count=0. FIFO pointers=0, sync flops=0, state=IDLE.
//   rst=1 mid-handshake aborts the handshake and discards FIFO contents.
// - Synchroniser: send -> s1 -> s2 (two flops). FSM uses only s2; data_in is sampled only when s2=1.
// - FSM IDLE:
//   - s2=1 and count<DEPTH: push data_in, ack<=1, go ACK.
//   - s2=1 and count==DEPTH: stay IDLE, ack stays 0 (CPU stalls; no drop, no overwrite).
// - FSM ACK: hold ack=1 until s2=0, then ack<=0 and go IDLE. Exactly one push per handshake.
// - Latency: send sampled high by s1 at edge N -> s2=1 after N+1 -> push and ack=1 at edge N+2
//   (FIFO not full).
// - Release: send low sampled by s1 at edge M -> ack=0 at edge M+2.
// - Back-to-back: a new send rise while in ACK is not seen until after ack falls. No word lost.
// - FIFO:
//   - out_data is the head entry; out_valid=(count!=0).
//   - Pop on out_valid & out_ready; no pop when empty.
//   - Push and pop in the same cycle: count unchanged, both pointers advance.
//   - Push is gated by count<DEPTH evaluated before the pop. A full FIFO stalls the CPU for one
//     extra cycle even if popped that cycle.
//   - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
// CONFIGURATION
// - RX_PARITY_EN defined:
//   - Adds input par_in (1) and output par_err (1, reset 0).
//   - On each push, even parity of {data_in,par_in} is checked.
//   - Mismatch: word is NOT pushed, ack handshake still completes, par_err sets sticky until rst.
// - RX_PARITY_EN undefined: no par_in/par_err ports; every handshake pushes its word.
// TESTING
// - Reset 10 cycles, send=0 -> ack=0, out_valid=0, count=0 throughout.
// - Handshake send=1, data_in=8'hA5, out_ready=0:
//   - ack=1 exactly 3 edges after the send rise; count=1; out_data=A5.
//   - Then send=0 -> ack=0 2-3 edges later.
// - Fill: 4 handshakes (11,22,33,44), out_ready=0, then a 5th send=1 data 55:
//   - ack stays 0, count=4.
//   - out_ready=1 one cycle -> out_data=22, then ack rises and count returns to 4 with 55 at tail.
// - Drain order: after the fill, hold out_ready=1 -> out_data sequence 22,33,44,55, then
//   out_valid=0, count=0.
// - Reset mid-handshake: rst=1 while ack=1 and count=2 -> next edge ack=0, count=0, out_valid=0.
//   Re-handshake after rst=0 works normally.
// - RX_PARITY_EN: data 8'h03 with par_in=1 -> par_err=1, count unchanged, ack still pulses.
//   data 8'h03 with par_in=0 -> pushed.

Source files
------------

// File: rtl/periph_async_rx.sv
// Receive side of the CPU send/ack 4-phase link: synchronises send, buffers words in a FIFO
// and presents them on valid/ready. Optional parity checking is enabled by RX_PARITY_EN.
module periph_async_rx #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send,
    input  logic [DATA_W-1:0] data_in,
`ifdef RX_PARITY_EN
    input  logic              par_in,
    output logic              par_err,
`endif
    output logic              ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Handshake: a word is taken while IDLE sees s2=1 and the FIFO is not full
    // (occupancy before any same-cycle pop); ack stays high until s2 drops.
    // Downstream: the head word moves on any cycle with out_valid & out_ready.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               s1;
    logic               s2;
    logic               accept;
    logic               par_ok;
    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (s2 && (count_q < CNT_W'(DEPTH))) begin
                    accept     = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!s2) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef RX_PARITY_EN
    assign par_ok = ~^{data_in, par_in};
`else
    assign par_ok = 1'b1;
`endif

    assign push = accept & par_ok;
    assign pop  = (count_q != '0) & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ack     <= 1'b0;
            s1      <= 1'b0;
            s2      <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            s1    <= send;
            s2    <= s1;
            state <= state_next;
            ack   <= (state_next == ACK);
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef RX_PARITY_EN
    // Sticky: once a bad word is refused, the flag holds until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (accept && !par_ok) begin
            par_err <= 1'b1;
        end
    end
`endif

    assign out_data  = mem[rd_ptr];
    assign out_valid = (count_q != '0);
    assign count     = count_q;

endmodule
